// File: rtl/sqr_wav_gen_multi.sv
// Multi-channel programmable square-wave generator with independent per-channel FSM, prescaler and shadowed settings.
// Optional burst mode (finite period count, DONE state, burst_n port) is enabled by defining SQR_GEN_BURST_EN.
module sqr_wav_gen_multi #(
    parameter int CH    = 4,
    parameter int W     = 8,
    parameter int PRESC = 10
`ifdef SQR_GEN_BURST_EN
    ,
    parameter int BW    = 8
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [CH-1:0]   en,
    input  logic [CH*W-1:0] high_m,
    input  logic [CH*W-1:0] low_n,
`ifdef SQR_GEN_BURST_EN
    input  logic [CH*BW-1:0] burst_n,
`endif
    output logic [CH-1:0]   sqr_out,
    output logic [CH-1:0]   period_done,
    output logic [CH-1:0]   busy
);

    localparam int            PW         = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
    localparam logic [W-1:0]  UNIT_ONE   = W'(1);
`ifdef SQR_GEN_BURST_EN
    localparam logic [BW-1:0] BURST_ONE  = BW'(1);
`endif

`ifdef SQR_GEN_BURST_EN
    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;
`endif

    for (genvar i = 0; i < CH; i++) begin : g_ch
        state_t        state, state_nxt;
        logic [PW-1:0] presc, presc_nxt;
        logic [W-1:0]  unit, unit_nxt;
        logic [W-1:0]  sh_high, sh_low;
        logic [W-1:0]  in_high, in_low;
        logic          capture, wrap, tick, high_end, low_end;

        assign in_high  = high_m[i*W +: W];
        assign in_low   = low_n[i*W +: W];
        assign tick     = (presc == PRESC_LAST);
        assign high_end = tick && (unit == sh_high - UNIT_ONE);
        // A zero low shadow in LOW means both shadows are zero: re-sample every clock.
        assign low_end  = (sh_low == '0) || (tick && (unit == sh_low - UNIT_ONE));

`ifdef SQR_GEN_BURST_EN
        logic [BW-1:0] sh_burst, bcnt;
        logic [BW-1:0] in_burst;
        assign in_burst = burst_n[i*BW +: BW];
`endif

        always_comb begin
            state_nxt = state;
            capture   = 1'b0;
            wrap      = 1'b0;
            if (tick) begin
                presc_nxt = '0;
                unit_nxt  = unit + UNIT_ONE;
            end else begin
                presc_nxt = presc + PRESC_ONE;
                unit_nxt  = unit;
            end

            case (state)
                S_IDLE: begin
                    if (en[i]) begin
                        capture   = 1'b1;
                        state_nxt = (in_high != '0) ? S_HIGH : S_LOW;
                    end
                end
                S_HIGH: begin
                    if (high_end) begin
                        if (sh_low != '0) state_nxt = S_LOW;
                        else              wrap      = 1'b1;
                    end
                end
                S_LOW: begin
                    if (low_end) begin
                        if (sh_low != '0) begin
                            wrap = 1'b1;
                        end else begin
                            capture   = 1'b1;
                            state_nxt = (in_high != '0) ? S_HIGH : S_LOW;
                        end
                    end
                end
`ifdef SQR_GEN_BURST_EN
                S_DONE: ;
`endif
                default: state_nxt = S_IDLE;
            endcase

            // Period boundary: latch fresh settings and restart from the new high value.
            if (wrap) begin
                capture   = 1'b1;
                state_nxt = (in_high != '0) ? S_HIGH : S_LOW;
`ifdef SQR_GEN_BURST_EN
                if ((sh_burst != '0) && (bcnt == sh_burst - BURST_ONE))
                    state_nxt = S_DONE;
`endif
            end

            if (!en[i]) begin
                state_nxt = S_IDLE;
                capture   = 1'b0;
                wrap      = 1'b0;
            end

            if ((state_nxt != state) || capture || (state_nxt == S_IDLE)) begin
                presc_nxt = '0;
                unit_nxt  = '0;
            end
`ifdef SQR_GEN_BURST_EN
            if (state_nxt == S_DONE) begin
                presc_nxt = '0;
                unit_nxt  = '0;
            end
`endif
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state <= S_IDLE;
                presc <= '0;
                unit  <= '0;
            end else begin
                state <= state_nxt;
                presc <= presc_nxt;
                unit  <= unit_nxt;
            end
        end

        always_ff @(posedge clk) begin
            if (capture) begin
                sh_high <= in_high;
                sh_low  <= in_low;
            end
        end

`ifdef SQR_GEN_BURST_EN
        always_ff @(posedge clk) begin
            if ((state == S_IDLE) && en[i])
                sh_burst <= in_burst;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                                   bcnt <= '0;
            else if ((state == S_IDLE) || (state_nxt == S_IDLE)) bcnt <= '0;
            else if (wrap)                                bcnt <= bcnt + BURST_ONE;
        end
`endif

        assign sqr_out[i]     = (state == S_HIGH);
        assign period_done[i] = wrap;
        assign busy[i]        = (state == S_HIGH) || (state == S_LOW);
    end

endmodule

// File: tb/tb_sqr_wav_gen_multi.sv
// Self-checking bench for sqr_wav_gen_multi (default build): per-cycle expected outputs are queued, then popped and compared.
module tb_sqr_wav_gen_multi;

    localparam int CH    = 4;
    localparam int W     = 8;
    localparam int PRESC = 10;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [CH-1:0]   en = '0;
    logic [CH*W-1:0] high_m = '0;
    logic [CH*W-1:0] low_n = '0;
    logic [CH-1:0]   sqr_out, period_done, busy;

    int total = 0;
    int bad   = 0;
    logic [11:0] sb[$];

    sqr_wav_gen_multi #(.CH(CH), .W(W), .PRESC(PRESC)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .high_m(high_m), .low_n(low_n),
        .sqr_out(sqr_out), .period_done(period_done), .busy(busy)
    );

    always #5 clk = ~clk;

    // Expected {sqr, period_done, busy} for one channel k cycles after its first HIGH/LOW cycle.
    function automatic logic [2:0] chan(int h, int l, bit act, int k);
        int per;
        if (!act) return 3'b000;
        if (h == 0 && l == 0) return 3'b001;
        if (h == 0) begin
            per = l * PRESC;
            return {1'b0, (k % per) == per - 1, 1'b1};
        end
        if (l == 0) begin
            per = h * PRESC;
            return {1'b1, (k % per) == per - 1, 1'b1};
        end
        per = (h + l) * PRESC;
        return {(k % per) < h * PRESC, (k % per) == per - 1, 1'b1};
    endfunction

    function automatic logic [11:0] pack(logic [2:0] c0, logic [2:0] c1, logic [2:0] c2, logic [2:0] c3);
        return {c3[2], c2[2], c1[2], c0[2], c3[1], c2[1], c1[1], c0[1], c3[0], c2[0], c1[0], c0[0]};
    endfunction

    task automatic set_ch(int c, int h, int l);
        high_m[c*W +: W] = W'(h);
        low_n[c*W +: W]  = W'(l);
    endtask

    task automatic go_idle();
        en = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [11:0] got;
        rst_n = 1'b0;
        #12;
        got = {sqr_out, period_done, busy};
        total++;
        if (got !== 12'h000) begin bad++; $display("FAIL reset_state got=%h want=000", got); end
        en = '1;
        set_ch(0, 3, 2);
        @(negedge clk);
        got = {sqr_out, period_done, busy};
        total++;
        if (got !== 12'h000) begin bad++; $display("FAIL reset_holds got=%h want=000", got); end
        en = '0;
        rst_n = 1'b1;
        @(negedge clk);
        got = {sqr_out, period_done, busy};
        total++;
        if (got !== 12'h000) begin bad++; $display("FAIL idle_after_reset got=%h want=000", got); end
    endtask

    task automatic test_basic();
        logic [11:0] got, exp;
        go_idle();
        set_ch(0, 3, 2); set_ch(1, 0, 5); set_ch(2, 4, 0); set_ch(3, 1, 1);
        en = 4'b0111;
        for (int k = 0; k < 120; k++)
            sb.push_back(pack(chan(3, 2, 1, k), chan(0, 5, 1, k), chan(4, 0, 1, k), chan(1, 1, 0, k)));
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            exp = sb.pop_front();
            got = {sqr_out, period_done, busy};
            total++;
            if (got !== exp) begin bad++; $display("FAIL basic k=%0d got=%h want=%h", k, got, exp); end
        end
    endtask

    task automatic test_shadow();
        logic [11:0] got, exp;
        go_idle();
        set_ch(0, 3, 2);
        en = 4'b0001;
        for (int k = 0; k < 140; k++)
            sb.push_back(pack((k < 50) ? chan(3, 2, 1, k) : chan(6, 2, 1, k - 50), 3'b0, 3'b0, 3'b0));
        for (int k = 0; k < 140; k++) begin
            @(negedge clk);
            exp = sb.pop_front();
            got = {sqr_out, period_done, busy};
            total++;
            if (got !== exp) begin bad++; $display("FAIL shadow k=%0d got=%h want=%h", k, got, exp); end
            if (k == 10) set_ch(0, 6, 2);
        end
    endtask

    task automatic test_stop();
        logic [11:0] got, exp;
        go_idle();
        set_ch(0, 3, 2);
        en = 4'b0001;
        for (int k = 0; k < 36; k++) sb.push_back(pack(chan(3, 2, 1, k), 3'b0, 3'b0, 3'b0));
        for (int k = 0; k < 20; k++) sb.push_back(12'h000);
        for (int k = 0; k < 55; k++) sb.push_back(pack(chan(3, 2, 1, k), 3'b0, 3'b0, 3'b0));
        for (int k = 0; k < 111; k++) begin
            @(negedge clk);
            exp = sb.pop_front();
            got = {sqr_out, period_done, busy};
            total++;
            if (got !== exp) begin bad++; $display("FAIL stop k=%0d got=%h want=%h", k, got, exp); end
            if (k == 35) en = 4'b0000;
            if (k == 55) en = 4'b0001;
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] got, exp;
        go_idle();
        set_ch(0, 3, 2); set_ch(1, 2, 2); set_ch(2, 4, 0); set_ch(3, 1, 1);
        en = 4'b1111;
        for (int k = 0; k < 5; k++)
            sb.push_back(pack(chan(3, 2, 1, k), chan(2, 2, 1, k), chan(4, 0, 1, k), chan(1, 1, 1, k)));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            exp = sb.pop_front();
            got = {sqr_out, period_done, busy};
            total++;
            if (got !== exp) begin bad++; $display("FAIL pre_reset k=%0d got=%h want=%h", k, got, exp); end
        end
        #2 rst_n = 1'b0;
        #1;
        got = {sqr_out, period_done, busy};
        total++;
        if (got !== 12'h000) begin bad++; $display("FAIL async_reset got=%h want=000", got); end
        @(negedge clk);
        got = {sqr_out, period_done, busy};
        total++;
        if (got !== 12'h000) begin bad++; $display("FAIL reset_held got=%h want=000", got); end
        rst_n = 1'b1;
        for (int k = 0; k < 60; k++)
            sb.push_back(pack(chan(3, 2, 1, k), chan(2, 2, 1, k), chan(4, 0, 1, k), chan(1, 1, 1, k)));
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            exp = sb.pop_front();
            got = {sqr_out, period_done, busy};
            total++;
            if (got !== exp) begin bad++; $display("FAIL post_reset k=%0d got=%h want=%h", k, got, exp); end
        end
    endtask

    task automatic test_degenerate();
        logic [11:0] got, exp;
        go_idle();
        set_ch(0, 1, 1); set_ch(1, 0, 0); set_ch(2, 0, 0); set_ch(3, 1, 1);
        en = 4'b0111;
        for (int k = 0; k < 80; k++)
            sb.push_back(pack(chan(1, 1, 1, k), (k < 5) ? chan(0, 0, 1, k) : chan(0, 3, 1, k - 5),
                              chan(0, 0, 1, k), 3'b0));
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            exp = sb.pop_front();
            got = {sqr_out, period_done, busy};
            total++;
            if (got !== exp) begin bad++; $display("FAIL degenerate k=%0d got=%h want=%h", k, got, exp); end
            if (k == 4) set_ch(1, 0, 3);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_shadow();
        test_stop();
        test_reset_mid();
        test_degenerate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
